exu_bjp_resolve: RTL and testbench

- Parametrised branch/jump resolution unit in the EXU.
- Resolves JAL, JALR and all six conditional branches:
  - computes target and link address;
  - compares the actual outcome with the fetch-time prediction;
  - issues a redirect/flush to the IFU over a valid/ready handshake.
- Owns a PC-indexed table of 2-bit saturating counters (BHT). The IFU reads it for prediction; it is trained on resolved conditional branches.

---
 rtl/exu_bjp_resolve_pkg.sv | 39 +++
 rtl/exu_bjp_resolve_if.sv | 41 ++++
 rtl/exu_bjp_resolve_bht.sv | 33 +++
 rtl/exu_bjp_resolve.sv | 146 ++++++++++++++
 tb/tb_exu_bjp_resolve.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exu_bjp_resolve_pkg.sv
// Shared constants for the branch/jump resolution unit: op and compare bit
// positions, BHT counter encodings and the redirect FSM states.
package bjp_pkg;

    localparam int OP_JAL  = 7;
    localparam int OP_JALR = 6;
    localparam int OP_BEQ  = 5;
    localparam int OP_BNE  = 4;
    localparam int OP_BLT  = 3;
    localparam int OP_BGE  = 2;
    localparam int OP_BLTU = 1;
    localparam int OP_BGEU = 0;

    localparam int CMP_SLT  = 2;
    localparam int CMP_SLTU = 1;
    localparam int CMP_EQ   = 0;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } bjp_state_e;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != CTR_ST) begin
            nxt = ctr + 2'b01;
        end else if (!taken && ctr != CTR_SNT) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/exu_bjp_resolve_if.sv
// Request, result, prediction and redirect signals of the resolution unit.
// The slave modport is the unit itself; master is the surrounding pipeline.
interface exu_bjp_resolve_if #(
    parameter int XLEN = 32
);
    logic            i_req_valid;
    logic            o_req_ready;
    logic [XLEN-1:0] i_req_pc;
    logic [XLEN-1:0] i_req_imm;
    logic [XLEN-1:0] i_req_rs1;
    logic [7:0]      i_req_op;
    logic [2:0]      i_req_cmp;
    logic            i_req_pred_taken;
    logic [XLEN-1:0] i_pred_pc;
    logic            o_pred_taken;
    logic            o_rsl_valid;
    logic            i_rsl_ready;
    logic            o_rsl_taken;
    logic [XLEN-1:0] o_rsl_target;
    logic [XLEN-1:0] o_rsl_link;
    logic            o_rsl_mispred;
    logic            o_rsl_misalign;
    logic            o_flush_valid;
    logic            i_flush_ready;
    logic [XLEN-1:0] o_flush_pc;

    modport master (
        output i_req_valid, i_req_pc, i_req_imm, i_req_rs1, i_req_op, i_req_cmp,
               i_req_pred_taken, i_pred_pc, i_rsl_ready, i_flush_ready,
        input  o_req_ready, o_pred_taken, o_rsl_valid, o_rsl_taken, o_rsl_target,
               o_rsl_link, o_rsl_mispred, o_rsl_misalign, o_flush_valid, o_flush_pc
    );

    modport slave (
        input  i_req_valid, i_req_pc, i_req_imm, i_req_rs1, i_req_op, i_req_cmp,
               i_req_pred_taken, i_pred_pc, i_rsl_ready, i_flush_ready,
        output o_req_ready, o_pred_taken, o_rsl_valid, o_rsl_taken, o_rsl_target,
               o_rsl_link, o_rsl_mispred, o_rsl_misalign, o_flush_valid, o_flush_pc
    );

endinterface

// File: rtl/exu_bjp_resolve_bht.sv
// Branch history table: 2-bit saturating counters with a combinational read
// port for the IFU and one synchronous training port.
module bjp_bht
    import bjp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr [DEPTH];

    // A read of the index being trained this cycle still sees the old count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= CTR_WNT;
            end
        end else if (upd_en) begin
            ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
        end
    end

    assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/exu_bjp_resolve.sv
// Branch/jump resolution: outcome, target, link, mispredict and IFU redirect.
// Define BJP_MISALIGN_CHK_EN to trap misaligned taken targets instead of redirecting.
module exu_bjp_resolve
    import bjp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    exu_bjp_resolve_if.slave bus
);

    localparam int BHT_IDX_W = $clog2(BHT_DEPTH);

    logic [7:0]      op;
    logic            eq, slt, sltu;
    logic            is_cond, cond_taken, mispred_raw;
    logic            req_taken, req_mispred, req_misalign, req_upd;
    logic [XLEN-1:0] req_target, req_link;

    logic                 rsl_valid, rsl_taken, rsl_mispred, rsl_misalign, rsl_upd;
    logic [XLEN-1:0]      rsl_target, rsl_link, flush_pc;
    logic [BHT_IDX_W-1:0] rsl_idx;

    bjp_state_e state, state_next;
    logic       flush_valid, req_ready, req_fire, rsl_fire;

    assign op   = bus.i_req_op;
    assign eq   = bus.i_req_cmp[CMP_EQ];
    assign slt  = bus.i_req_cmp[CMP_SLT];
    assign sltu = bus.i_req_cmp[CMP_SLTU];

    always_comb begin
        is_cond    = |op[OP_BEQ:OP_BGEU];
        cond_taken = (op[OP_BEQ]  &  eq)   | (op[OP_BNE]  & ~eq)  |
                     (op[OP_BLT]  &  slt)  | (op[OP_BGE]  & ~slt) |
                     (op[OP_BLTU] &  sltu) | (op[OP_BGEU] & ~sltu);
        req_taken  = op[OP_JAL] | op[OP_JALR] | cond_taken;
        req_target = op[OP_JALR] ? ((bus.i_req_rs1 + bus.i_req_imm) & ~XLEN'(1))
                                 : (bus.i_req_pc + bus.i_req_imm);
        req_link   = bus.i_req_pc + XLEN'(4);

        // jalr has no target prediction, so it always redirects.
        if (is_cond) begin
            mispred_raw = req_taken ^ bus.i_req_pred_taken;
        end else if (op[OP_JAL]) begin
            mispred_raw = ~bus.i_req_pred_taken;
        end else begin
            mispred_raw = op[OP_JALR];
        end

`ifdef BJP_MISALIGN_CHK_EN
        req_misalign = req_taken & (|req_target[1:0]);
`else
        req_misalign = 1'b0;
`endif
        req_mispred = mispred_raw & ~req_misalign;
        req_upd     = is_cond & ~req_misalign;
    end

    assign req_ready = (state == ST_IDLE) & (~rsl_valid | bus.i_rsl_ready);
    assign req_fire  = bus.i_req_valid & req_ready;
    assign rsl_fire  = rsl_valid & bus.i_rsl_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        flush_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_fire && req_mispred) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_valid = 1'b1;
                if (bus.i_flush_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result fields only load on an accepted request, which keeps them stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsl_valid    <= 1'b0;
            rsl_taken    <= 1'b0;
            rsl_target   <= '0;
            rsl_link     <= '0;
            rsl_mispred  <= 1'b0;
            rsl_misalign <= 1'b0;
            rsl_upd      <= 1'b0;
            rsl_idx      <= '0;
            flush_pc     <= '0;
        end else begin
            if (req_fire) begin
                rsl_valid    <= 1'b1;
                rsl_taken    <= req_taken;
                rsl_target   <= req_target;
                rsl_link     <= req_link;
                rsl_mispred  <= req_mispred;
                rsl_misalign <= req_misalign;
                rsl_upd      <= req_upd;
                rsl_idx      <= bus.i_req_pc[BHT_IDX_W+1:2];
            end else if (rsl_fire) begin
                rsl_valid <= 1'b0;
            end
            if (req_fire && req_mispred) begin
                flush_pc <= req_taken ? req_target : req_link;
            end
        end
    end

    bjp_bht #(
        .DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (bus.i_pred_pc[BHT_IDX_W+1:2]),
        .rd_taken  (bus.o_pred_taken),
        .upd_en    (rsl_fire & rsl_upd),
        .upd_idx   (rsl_idx),
        .upd_taken (rsl_taken)
    );

    assign bus.o_req_ready    = req_ready;
    assign bus.o_rsl_valid    = rsl_valid;
    assign bus.o_rsl_taken    = rsl_taken;
    assign bus.o_rsl_target   = rsl_target;
    assign bus.o_rsl_link     = rsl_link;
    assign bus.o_rsl_mispred  = rsl_mispred;
    assign bus.o_rsl_misalign = rsl_misalign;
    assign bus.o_flush_valid  = flush_valid;
    assign bus.o_flush_pc     = flush_pc;

endmodule

// File: tb/tb_exu_bjp_resolve.sv
// Scoreboard bench for exu_bjp_resolve: results and redirects are predicted on
// request acceptance and checked when the DUT hands them over.
module tb_exu_bjp_resolve;
    import bjp_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exu_bjp_resolve_if #(.XLEN(XLEN)) bus();

    exu_bjp_resolve #(
        .XLEN      (XLEN),
        .BHT_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        mispred;
        logic        misalign;
    } rsl_t;

    typedef struct {
        rsl_t       r;
        logic       upd;
        logic [5:0] idx;
    } exp_t;

    exp_t        rsl_q[$];
    logic [31:0] flush_q[$];
    logic [1:0]  bht_m [DEPTH];
    exp_t        mon_e;
    rsl_t        mon_a;
    logic [31:0] mon_f;
    int          n_compared   = 0;
    int          n_mismatched = 0;

    function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic exp_t model(input logic [7:0] op, input logic [31:0] pc,
                                   input logic [31:0] imm, input logic [31:0] rs1,
                                   input logic [2:0] cmp, input logic pred);
        exp_t        e;
        logic        t, cond_b;
        logic [31:0] tgt;
        cond_b = 1'b1;
        t      = 1'b0;
        case (op)
            8'h80:   begin cond_b = 1'b0; t = 1'b1; end
            8'h40:   begin cond_b = 1'b0; t = 1'b1; end
            8'h20:   t = cmp[0];
            8'h10:   t = !cmp[0];
            8'h08:   t = cmp[2];
            8'h04:   t = !cmp[2];
            8'h02:   t = cmp[1];
            8'h01:   t = !cmp[1];
            default: cond_b = 1'b0;
        endcase
        tgt = (op == 8'h40) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        e.r.taken    = t;
        e.r.target   = tgt;
        e.r.link     = pc + 32'd4;
        e.r.misalign = 1'b0;
        if (cond_b)           e.r.mispred = (t != pred);
        else if (op == 8'h80) e.r.mispred = !pred;
        else                  e.r.mispred = (op == 8'h40);
`ifdef BJP_MISALIGN_CHK_EN
        if (t && tgt[1:0] != 2'b00) begin
            e.r.misalign = 1'b1;
            e.r.mispred  = 1'b0;
        end
`endif
        e.upd = cond_b && !e.r.misalign;
        e.idx = pc[7:2];
        return e;
    endfunction

    // Monitor: pop results/redirects first, then record any request accepted at the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_rsl_valid && bus.i_rsl_ready) begin
                n_compared++;
                if (rsl_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL rsl_unexpected: result valid with nothing outstanding");
                end else begin
                    mon_e = rsl_q.pop_front();
                    mon_a = {bus.o_rsl_taken, bus.o_rsl_target, bus.o_rsl_link,
                             bus.o_rsl_mispred, bus.o_rsl_misalign};
                    if (mon_a !== mon_e.r) begin
                        n_mismatched++;
                        $display("[TB] FAIL rsl_fields: got %h want %h", mon_a, mon_e.r);
                    end
                    if (mon_e.upd) bht_m[mon_e.idx] = sat_upd(bht_m[mon_e.idx], mon_e.r.taken);
                end
            end
            if (bus.o_flush_valid && bus.i_flush_ready) begin
                n_compared++;
                if (flush_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL flush_unexpected: flush_pc %h", bus.o_flush_pc);
                end else begin
                    mon_f = flush_q.pop_front();
                    if (bus.o_flush_pc !== mon_f) begin
                        n_mismatched++;
                        $display("[TB] FAIL flush_pc: got %h want %h", bus.o_flush_pc, mon_f);
                    end
                end
            end
            if (bus.i_req_valid && bus.o_req_ready) begin
                mon_e = model(bus.i_req_op, bus.i_req_pc, bus.i_req_imm, bus.i_req_rs1,
                              bus.i_req_cmp, bus.i_req_pred_taken);
                rsl_q.push_back(mon_e);
                if (mon_e.r.mispred)
                    flush_q.push_back(mon_e.r.taken ? mon_e.r.target : mon_e.r.link);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.i_req_valid)
            assert ($onehot0(bus.i_req_op)) else $error("[TB] illegal multi-hot op %b", bus.i_req_op);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] op, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic [31:0] rs1,
                                  input logic [2:0] cmp, input logic pred);
        int n = 0;
        bus.i_req_op         = op;
        bus.i_req_pc         = pc;
        bus.i_req_imm        = imm;
        bus.i_req_rs1        = rs1;
        bus.i_req_cmp        = cmp;
        bus.i_req_pred_taken = pred;
        bus.i_req_valid      = 1'b1;
        while (!bus.o_req_ready && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL req_timeout: ready %b required 1", bus.o_req_ready);
        end
        step();
        bus.i_req_valid = 1'b0;
        bus.i_req_op    = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        for (int i = 0; i < DEPTH; i++) bht_m[i] = CTR_WNT;
        rsl_q.delete();
        flush_q.delete();
    endtask

    task automatic test_reset();
        bus.i_rsl_ready   = 1'b1;
        bus.i_flush_ready = 1'b1;
        bus.i_pred_pc     = 32'h100;
        do_reset();
        n_compared++;
        if ({bus.o_rsl_valid, bus.o_flush_valid, bus.o_rsl_taken, bus.o_rsl_mispred} !== 4'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags: got %b want 0000",
                     {bus.o_rsl_valid, bus.o_flush_valid, bus.o_rsl_taken, bus.o_rsl_mispred});
        end
        n_compared++;
        if (bus.o_rsl_target !== 32'h0 || bus.o_flush_pc !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_data: target %h flush_pc %h want 0", bus.o_rsl_target, bus.o_flush_pc);
        end
        rst_n = 1'b1;
        step();
        n_compared++;
        if (bus.o_req_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ready: got %b want 1", bus.o_req_ready);
        end
        n_compared++;
        if (bus.o_pred_taken !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_pred: got %b want 0", bus.o_pred_taken);
        end
    endtask

    task automatic test_beq_taken();
        bus.i_pred_pc = 32'h100;
        apply_stimulus(8'h20, 32'h100, 32'h20, 32'h0, 3'b001, 1'b0);
        n_compared++;
        if (bus.o_flush_valid !== 1'b1 || bus.o_flush_pc !== 32'h120 || bus.o_rsl_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL beq_flush: fv %b pc %h rv %b want 1 120 1",
                     bus.o_flush_valid, bus.o_flush_pc, bus.o_rsl_valid);
        end
        n_compared++;
        if (bus.o_req_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL beq_ready_in_flush: got %b want 0", bus.o_req_ready);
        end
        step();
        n_compared++;
        if (bus.o_pred_taken !== 1'b1 || bus.o_req_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL beq_bht: pred %b ready %b want 1 1", bus.o_pred_taken, bus.o_req_ready);
        end
    endtask

    task automatic test_bne_not_taken();
        bus.i_pred_pc = 32'h200;
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(8'h10, 32'h200, 32'h40, 32'h0, 3'b001, 1'b0);
            n_compared++;
            if (bus.o_flush_valid !== 1'b0 || bus.o_rsl_link !== 32'h204 || bus.o_rsl_taken !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL bne_result[%0d]: fv %b link %h taken %b want 0 204 0",
                         k, bus.o_flush_valid, bus.o_rsl_link, bus.o_rsl_taken);
            end
        end
        step();
        n_compared++;
        if (bus.o_pred_taken !== bht_m[0][1]) begin
            n_mismatched++;
            $display("[TB] FAIL bne_bht: got %b want %b", bus.o_pred_taken, bht_m[0][1]);
        end
        // One increment from a floored counter must still predict not-taken.
        apply_stimulus(8'h20, 32'h200, 32'h40, 32'h0, 3'b001, 1'b1);
        step();
        n_compared++;
        if (bus.o_pred_taken !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL bne_floor: got %b want 0", bus.o_pred_taken);
        end
    endtask

    task automatic test_jalr();
        apply_stimulus(8'h40, 32'h800, 32'h4, 32'h1003, 3'b000, 1'b0);
        n_compared++;
        if (bus.o_rsl_target !== 32'h1006) begin
            n_mismatched++;
            $display("[TB] FAIL jalr_target: got %h want 00001006", bus.o_rsl_target);
        end
`ifdef BJP_MISALIGN_CHK_EN
        n_compared++;
        if (bus.o_rsl_misalign !== 1'b1 || bus.o_rsl_mispred !== 1'b0 || bus.o_flush_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL jalr_misalign: mis %b mp %b fv %b want 1 0 0",
                     bus.o_rsl_misalign, bus.o_rsl_mispred, bus.o_flush_valid);
        end
`else
        n_compared++;
        if (bus.o_rsl_misalign !== 1'b0 || bus.o_rsl_mispred !== 1'b1 ||
            bus.o_flush_valid !== 1'b1 || bus.o_flush_pc !== 32'h1006) begin
            n_mismatched++;
            $display("[TB] FAIL jalr_flush: mis %b mp %b fv %b pc %h want 0 1 1 1006",
                     bus.o_rsl_misalign, bus.o_rsl_mispred, bus.o_flush_valid, bus.o_flush_pc);
        end
`endif
        step();
        step();
    endtask

    task automatic test_flush_backpressure();
        bus.i_flush_ready = 1'b0;
        apply_stimulus(8'h80, 32'h300, 32'h100, 32'h0, 3'b000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            n_compared++;
            if (bus.o_flush_valid !== 1'b1 || bus.o_flush_pc !== 32'h400 || bus.o_req_ready !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL flush_hold[%0d]: fv %b pc %h ready %b want 1 400 0",
                         k, bus.o_flush_valid, bus.o_flush_pc, bus.o_req_ready);
            end
            step();
        end
        bus.i_flush_ready = 1'b1;
        step();
        n_compared++;
        if (bus.o_flush_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL flush_release: fv %b ready %b want 0 1", bus.o_flush_valid, bus.o_req_ready);
        end
    endtask

    task automatic test_rsl_hold();
        bus.i_rsl_ready = 1'b0;
        apply_stimulus(8'h02, 32'h600, 32'h8, 32'h0, 3'b010, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_compared++;
            if (bus.o_rsl_valid !== 1'b1 || bus.o_rsl_target !== 32'h608 || bus.o_req_ready !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL rsl_hold[%0d]: rv %b target %h ready %b want 1 608 0",
                         k, bus.o_rsl_valid, bus.o_rsl_target, bus.o_req_ready);
            end
            step();
        end
        bus.i_rsl_ready = 1'b1;
        #1;
        n_compared++;
        if (bus.o_req_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rsl_release_ready: got %b want 1", bus.o_req_ready);
        end
        step();
        n_compared++;
        if (bus.o_rsl_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rsl_drain: got %b want 0", bus.o_rsl_valid);
        end
    endtask

    task automatic test_nonbranch();
        apply_stimulus(8'h00, 32'h700, 32'h10, 32'h0, 3'b111, 1'b1);
        n_compared++;
        if (bus.o_flush_valid !== 1'b0 || bus.o_rsl_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL nonbranch: fv %b rv %b want 0 1", bus.o_flush_valid, bus.o_rsl_valid);
        end
        step();
    endtask

    task automatic test_bht_saturate();
        logic exp_pred [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        bus.i_pred_pc = 32'h544;
        // Back-to-back: each check sees the counter before the pending result trains it.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(8'h08, 32'h544, 32'h10, 32'h0, 3'b100, 1'b1);
            n_compared++;
            if (bus.o_pred_taken !== exp_pred[k]) begin
                n_mismatched++;
                $display("[TB] FAIL bht_inc[%0d]: got %b want %b", k, bus.o_pred_taken, exp_pred[k]);
            end
        end
        step();
        bus.i_pred_pc = 32'h644;
        #1;
        n_compared++;
        if (bus.o_pred_taken !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL bht_alias: got %b want 1", bus.o_pred_taken);
        end
        bus.i_pred_pc = 32'h544;
        apply_stimulus(8'h04, 32'h544, 32'h10, 32'h0, 3'b100, 1'b0);
        step();
        n_compared++;
        if (bus.o_pred_taken !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL bht_sat_dec1: got %b want 1", bus.o_pred_taken);
        end
        apply_stimulus(8'h04, 32'h544, 32'h10, 32'h0, 3'b100, 1'b0);
        step();
        n_compared++;
        if (bus.o_pred_taken !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL bht_sat_dec2: got %b want 0", bus.o_pred_taken);
        end
    endtask

    task automatic test_reset_in_flush();
        apply_stimulus(8'h08, 32'h544, 32'h10, 32'h0, 3'b100, 1'b1);
        step();
        bus.i_flush_ready = 1'b0;
        apply_stimulus(8'h80, 32'h900, 32'h40, 32'h0, 3'b000, 1'b0);
        n_compared++;
        if (bus.o_flush_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rif_setup: fv %b want 1", bus.o_flush_valid);
        end
        rst_n = 1'b0;
        step();
        n_compared++;
        if (bus.o_flush_valid !== 1'b0 || bus.o_rsl_valid !== 1'b0 || bus.o_pred_taken !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rif_clear: fv %b rv %b pred %b want 0 0 0",
                     bus.o_flush_valid, bus.o_rsl_valid, bus.o_pred_taken);
        end
        for (int i = 0; i < DEPTH; i++) bht_m[i] = CTR_WNT;
        rsl_q.delete();
        flush_q.delete();
        rst_n = 1'b1;
        bus.i_flush_ready = 1'b1;
        step();
        n_compared++;
        if (bus.o_req_ready !== 1'b1 || bus.o_flush_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rif_idle: ready %b fv %b want 1 0", bus.o_req_ready, bus.o_flush_valid);
        end
    endtask

    initial begin
        bus.i_req_valid      = 1'b0;
        bus.i_req_pc         = '0;
        bus.i_req_imm        = '0;
        bus.i_req_rs1        = '0;
        bus.i_req_op         = 8'h00;
        bus.i_req_cmp        = 3'b000;
        bus.i_req_pred_taken = 1'b0;
        bus.i_pred_pc        = '0;
        bus.i_rsl_ready      = 1'b1;
        bus.i_flush_ready    = 1'b1;

        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_jalr();
        test_flush_backpressure();
        test_rsl_hold();
        test_nonbranch();
        test_bht_saturate();
        test_reset_in_flush();

        step();
        step();
        n_compared++;
        if (rsl_q.size() != 0 || flush_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL drain: %0d results and %0d flushes outstanding, want 0",
                     rsl_q.size(), flush_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
